// File: rtl/csr_file.sv
// Machine-mode CSR register file.
// Executes decoder-issued CSR ops (write/set/clear with a register or zimm
// source) and returns the old CSR value for rd. Also holds the 64-bit
// cycle/instret counters and the trap entry / mret state. The registered
// redirect outputs drive the fetch PC mux.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_adr,
  input  logic        csr_read_en,
  input  logic        csr_wr_en,
  input  logic [1:0]  csr_op_ctr,
  input  logic        csr_imm_en,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        instr_retired,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADR_MISA      = 12'h301;
  localparam logic [11:0] ADR_MTVEC     = 12'h305;
  localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADR_MEPC      = 12'h341;
  localparam logic [11:0] ADR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADR_MHARTID   = 12'hF14;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_SET   = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_NONE  = 2'd3;

  // Architectural state
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:2] mepc_hi;
  logic [31:0] mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] mstatus_val;
  logic [31:0] mepc_val;
  logic [31:0] old_val;
  logic        adr_hit;
  logic [31:0] src_val;
  logic [31:0] new_val;
  logic        do_write;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mepc_val    = {mepc_hi, 2'b00};

  // Address decode: select the current value and flag implemented addresses.
  always_comb begin
    adr_hit = 1'b1;
    old_val = 32'h0;
    case (csr_adr)
      ADR_MSTATUS:                 old_val = mstatus_val;
      ADR_MISA:                    old_val = MISA_VAL;
      ADR_MTVEC:                   old_val = mtvec;
      ADR_MSCRATCH:                old_val = mscratch;
      ADR_MEPC:                    old_val = mepc_val;
      ADR_MCAUSE:                  old_val = mcause;
      ADR_MCYCLE,   ADR_CYCLE:     old_val = mcycle[31:0];
      ADR_MCYCLEH,  ADR_CYCLEH:    old_val = mcycle[63:32];
      ADR_MINSTRET, ADR_INSTRET:   old_val = minstret[31:0];
      ADR_MINSTRETH, ADR_INSTRETH: old_val = minstret[63:32];
      ADR_MVENDORID, ADR_MARCHID, ADR_MIMPID: old_val = 32'h0;
      ADR_MHARTID:                 old_val = HART_ID;
      default:                     adr_hit = 1'b0;
    endcase
  end

  // Illegal access: unimplemented address or any write into the read-only
  // 0xC00-0xFFF region, but only when an actual CSR op is being issued.
  assign illegal_csr = (csr_op_ctr != OP_NONE) &&
                       (!adr_hit || (csr_wr_en && (csr_adr[11:10] == 2'b11)));

  assign csr_rdata = (csr_read_en && !illegal_csr) ? old_val : 32'h0;

  // Compute the value the op would write back.
  always_comb begin
    src_val = csr_imm_en ? {27'b0, zimm} : rs1_data;
    new_val = old_val;
    case (csr_op_ctr)
      OP_WRITE: new_val = src_val;
      OP_SET:   new_val = old_val | src_val;
      OP_CLEAR: new_val = old_val & ~src_val;
      default:  new_val = old_val;
    endcase
  end

  // Trap and mret outrank the CSR write; an illegal op changes nothing.
  assign do_write = csr_wr_en && (csr_op_ctr != OP_NONE) && !illegal_csr &&
                    !trap_req && !mret;

  // Vectored mode only applies to interrupts (cause MSB set).
  assign trap_base   = {mtvec[31:2], 2'b00};
  assign trap_target = ((mtvec[1:0] == 2'b01) && trap_cause[31])
                       ? trap_base + {trap_cause[29:0], 2'b00}
                       : trap_base;

  // mstatus: trap entry saves MIE into MPIE, mret restores it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_req) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (do_write && (csr_adr == ADR_MSTATUS)) begin
      mstatus_mie  <= new_val[3];
      mstatus_mpie <= new_val[7];
    end
  end

  // Trap bookkeeping registers mepc and mcause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_hi <= 30'h0;
      mcause  <= 32'h0;
    end else if (trap_req) begin
      mepc_hi <= trap_pc[31:2];
      mcause  <= trap_cause;
    end else if (do_write) begin
      if (csr_adr == ADR_MEPC)   mepc_hi <= new_val[31:2];
      if (csr_adr == ADR_MCAUSE) mcause  <= new_val;
    end
  end

  // Software-only registers mtvec and mscratch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec    <= MTVEC_RESET;
      mscratch <= 32'h0;
    end else if (do_write) begin
      if (csr_adr == ADR_MTVEC)    mtvec    <= new_val;
      if (csr_adr == ADR_MSCRATCH) mscratch <= new_val;
    end
  end

  // Cycle counter: a write to one half replaces that half and freezes the
  // other for the cycle, so no increment carries into the written value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle <= 64'h0;
    end else if (do_write && (csr_adr == ADR_MCYCLE)) begin
      mcycle[31:0] <= new_val;
    end else if (do_write && (csr_adr == ADR_MCYCLEH)) begin
      mcycle[63:32] <= new_val;
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end

  // Retired-instruction counter, same write-wins rule as the cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minstret <= 64'h0;
    end else if (do_write && (csr_adr == ADR_MINSTRET)) begin
      minstret[31:0] <= new_val;
    end else if (do_write && (csr_adr == ADR_MINSTRETH)) begin
      minstret[63:32] <= new_val;
    end else if (instr_retired) begin
      minstret <= minstret + 64'd1;
    end
  end

  // One-cycle redirect pulse to the trap vector or back to mepc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_redirect <= 1'b0;
      redirect_pc <= 32'h0;
    end else if (trap_req) begin
      pc_redirect <= 1'b1;
      redirect_pc <= trap_target;
    end else if (mret) begin
      pc_redirect <= 1'b1;
      redirect_pc <= mepc_val;
    end else begin
      pc_redirect <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed testbench for csr_file: CSR ops, counters, trap/mret redirect,
// illegal accesses and asynchronous reset.
module tb_csr_file;

  logic        clk;
  logic        rst_n;
  logic [11:0] csr_adr;
  logic        csr_read_en;
  logic        csr_wr_en;
  logic [1:0]  csr_op_ctr;
  logic        csr_imm_en;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        instr_retired;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        pc_redirect;
  logic [31:0] redirect_pc;

  int checks;
  int failures;
  logic [31:0] val;
  logic [31:0] saved;

  csr_file dut (
    .clk(clk), .rst_n(rst_n),
    .csr_adr(csr_adr), .csr_read_en(csr_read_en), .csr_wr_en(csr_wr_en),
    .csr_op_ctr(csr_op_ctr), .csr_imm_en(csr_imm_en), .rs1_data(rs1_data),
    .zimm(zimm), .instr_retired(instr_retired), .trap_req(trap_req),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
    .csr_rdata(csr_rdata), .illegal_csr(illegal_csr),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    csr_read_en   = 1'b0;
    csr_wr_en     = 1'b0;
    csr_op_ctr    = 2'd3;
    csr_imm_en    = 1'b0;
    rs1_data      = 32'h0;
    zimm          = 5'h0;
    instr_retired = 1'b0;
    trap_req      = 1'b0;
    trap_cause    = 32'h0;
    trap_pc       = 32'h0;
    mret          = 1'b0;
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Combinational read without consuming a clock edge.
  task automatic read_csr(input logic [11:0] adr, output logic [31:0] data);
    csr_adr     = adr;
    csr_read_en = 1'b1;
    csr_wr_en   = 1'b0;
    csr_op_ctr  = 2'd3;
    #1;
    data = csr_rdata;
    csr_read_en = 1'b0;
  endtask

  // Issue one CSR op for a cycle; returns rdata seen before the edge.
  task automatic csr_cycle(input logic [11:0] adr, input logic [1:0] op,
                           input logic imm, input logic [31:0] src,
                           input logic [4:0] z, output logic [31:0] old);
    csr_adr     = adr;
    csr_read_en = 1'b1;
    csr_wr_en   = 1'b1;
    csr_op_ctr  = op;
    csr_imm_en  = imm;
    rs1_data    = src;
    zimm        = z;
    #1;
    old = csr_rdata;
    step();
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    csr_adr = 12'h0;
    rst_n   = 1'b0;

    // Reset state
    #12;
    read_csr(12'h305, val); check("rst_mtvec", val, 32'h0);
    read_csr(12'h300, val); check("rst_mstatus", val, 32'h0000_1800);
    read_csr(12'hB00, val); check("rst_mcycle", val, 32'h0);
    check("rst_redirect", {31'b0, pc_redirect}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Identification registers
    read_csr(12'h301, val); check("misa", val, 32'h4000_0100);
    read_csr(12'hF14, val); check("mhartid", val, 32'h0);

    // mscratch write / set / clear
    csr_cycle(12'h340, 2'd0, 1'b0, 32'hDEAD_BEEF, 5'h0, val);
    check("csrrw_old", val, 32'h0);
    csr_cycle(12'h340, 2'd1, 1'b1, 32'h0, 5'h10, val);
    check("csrrs_old", val, 32'hDEAD_BEEF);
    read_csr(12'h340, val); check("csrrs_new", val, 32'hDEAD_BEFF);
    csr_cycle(12'h340, 2'd2, 1'b0, 32'h0000_00FF, 5'h0, val);
    check("csrrc_old", val, 32'hDEAD_BEFF);
    read_csr(12'h340, val); check("csrrc_new", val, 32'hDEAD_BE00);

    // mepc low bits forced to zero, misa writes ignored
    csr_cycle(12'h341, 2'd0, 1'b0, 32'h0000_1003, 5'h0, val);
    read_csr(12'h341, val); check("mepc_align", val, 32'h0000_1000);
    csr_cycle(12'h301, 2'd0, 1'b0, 32'h0, 5'h0, val);
    read_csr(12'h301, val); check("misa_ro", val, 32'h4000_0100);

    // Counter carry from low to high half
    csr_cycle(12'hB00, 2'd0, 1'b0, 32'hFFFF_FFFF, 5'h0, val);
    read_csr(12'hB00, val); check("mcycle_wr", val, 32'hFFFF_FFFF);
    read_csr(12'hB80, val); check("mcycleh_pre", val, 32'h0);
    step();
    read_csr(12'hB00, val); check("mcycle_wrap", val, 32'h0);
    read_csr(12'hB80, val); check("mcycleh_carry", val, 32'h1);
    csr_cycle(12'hB00, 2'd0, 1'b0, 32'h5, 5'h0, val);
    read_csr(12'hB00, val); check("mcycle_5", val, 32'h5);
    step();
    read_csr(12'hB00, val); check("mcycle_6", val, 32'h6);
    read_csr(12'hC80, val); check("cycleh_alias", val, 32'h1);

    // minstret counts only retired instructions
    instr_retired = 1'b1;
    step(); step(); step();
    instr_retired = 1'b0;
    step();
    read_csr(12'hB02, val); check("minstret", val, 32'h3);

    // Trap entry, direct mode
    csr_cycle(12'h300, 2'd1, 1'b1, 32'h0, 5'h08, val);
    read_csr(12'h300, val); check("mie_set", val, 32'h0000_1808);
    csr_cycle(12'h305, 2'd0, 1'b0, 32'h0000_0100, 5'h0, val);
    trap_req = 1'b1; trap_cause = 32'h2; trap_pc = 32'h0000_2002;
    step();
    idle();
    check("trap_pulse", {31'b0, pc_redirect}, 32'h1);
    check("trap_target", redirect_pc, 32'h0000_0100);
    read_csr(12'h341, val); check("trap_mepc", val, 32'h0000_2000);
    read_csr(12'h342, val); check("trap_mcause", val, 32'h2);
    read_csr(12'h300, val); check("trap_mstatus", val, 32'h0000_1880);
    step();
    check("pulse_end", {31'b0, pc_redirect}, 32'h0);

    // mret back to mepc
    mret = 1'b1;
    step();
    idle();
    check("mret_pulse", {31'b0, pc_redirect}, 32'h1);
    check("mret_target", redirect_pc, 32'h0000_2000);
    read_csr(12'h300, val); check("mret_mstatus", val, 32'h0000_1888);
    step();

    // Vectored interrupt
    csr_cycle(12'h305, 2'd0, 1'b0, 32'h0000_0101, 5'h0, val);
    trap_req = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_3000;
    step();
    idle();
    check("vec_target", redirect_pc, 32'h0000_011C);
    read_csr(12'h342, val); check("vec_mcause", val, 32'h8000_0007);
    step();

    // Write to read-only counter is illegal and has no effect
    read_csr(12'hC00, saved);
    csr_adr = 12'hC00; csr_read_en = 1'b1; csr_wr_en = 1'b1;
    csr_op_ctr = 2'd0; rs1_data = 32'h0;
    #1;
    check("ro_illegal", {31'b0, illegal_csr}, 32'h1);
    check("ro_rdata", csr_rdata, 32'h0);
    step();
    idle();
    read_csr(12'hC00, val); check("ro_nochange", val, saved + 32'd1);

    // Unimplemented address
    csr_adr = 12'h7C0; csr_read_en = 1'b1; csr_wr_en = 1'b0; csr_op_ctr = 2'd1;
    #1;
    check("unimpl_illegal", {31'b0, illegal_csr}, 32'h1);
    csr_adr = 12'h340;
    #1;
    check("legal_read", {31'b0, illegal_csr}, 32'h0);
    idle();

    // Trap suppresses a same-cycle CSR write
    csr_adr = 12'h340; csr_read_en = 1'b1; csr_wr_en = 1'b1; csr_op_ctr = 2'd0;
    rs1_data = 32'h1234_5678;
    trap_req = 1'b1; trap_cause = 32'h5; trap_pc = 32'h0000_4000;
    step();
    idle();
    read_csr(12'h340, val); check("trap_blocks_wr", val, 32'hDEAD_BE00);

    // Back-to-back traps give back-to-back pulses
    trap_req = 1'b1; trap_cause = 32'h3;
    step();
    check("b2b_pulse1", {31'b0, pc_redirect}, 32'h1);
    step();
    check("b2b_pulse2", {31'b0, pc_redirect}, 32'h1);

    // Asynchronous reset drops a pending redirect immediately
    trap_req = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_redirect", {31'b0, pc_redirect}, 32'h0);
    read_csr(12'h340, val); check("async_mscratch", val, 32'h0);
    read_csr(12'h305, val); check("async_mtvec", val, 32'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
